// File: rtl/mc_ctrl_if.sv
// Control/status bundle between the multicycle main control FSM and the datapath/memory.
// master = control FSM side, slave = datapath/memory side.
interface mc_ctrl_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, instr_done, illegal_op
    );
endinterface

// File: rtl/mc_main_control.sv
// Multicycle main control FSM for the 16-bit MIPS datapath.
// Optional macro MC_ILLEGAL_TRAP_EN: undefined opcodes park the FSM in TRAP with illegal_op set.
module mc_main_control (
    input  logic       clk,
    input  logic       reset_n,
    mc_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        JUMP,
        WB_R,
        WB_I
`ifdef MC_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_e;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000,
        OP_ADDI  = 4'b0001,
        OP_ANDI  = 4'b0010,
        OP_ORI   = 4'b0011,
        OP_SLTI  = 4'b0100,
        OP_LW    = 4'b0101,
        OP_SW    = 4'b0110,
        OP_BEQ   = 4'b0111,
        OP_J     = 4'b1000
    } opcode_e;

    localparam logic [3:0] ALU_RTYPE = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b1001;
    localparam logic [3:0] ALU_OR    = 4'b1010;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    state_e     state_q, state_d;
    logic       started_q;
    logic       is_store_q, is_store_d;
    logic [3:0] exec_i_op_q, exec_i_op_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            started_q   <= 1'b0;
            is_store_q  <= 1'b0;
            exec_i_op_q <= ALU_ADD;
        end else begin
            state_q     <= state_d;
            started_q   <= 1'b1;
            is_store_q  <= is_store_d;
            exec_i_op_q <= exec_i_op_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d            = state_q;
        is_store_d         = is_store_q;
        exec_i_op_d        = exec_i_op_q;
        bus.pc_write       = 1'b0;
        bus.pc_write_cond  = 1'b0;
        bus.pc_source      = PCSRC_ALU;
        bus.iord           = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.ir_write       = 1'b0;
        bus.reg_dst        = 1'b0;
        bus.mem_to_reg     = 1'b0;
        bus.reg_write      = 1'b0;
        bus.alu_src_a      = 1'b0;
        bus.alu_src_b      = SRCB_RT;
        bus.alu_op         = ALU_RTYPE;
        bus.instr_done     = 1'b0;
        bus.illegal_op     = 1'b0;

        unique case (state_q)
            // Hold one extra cycle after reset release so the first FETCH lands on the second edge.
            IDLE: begin
                if (started_q) state_d = FETCH;
            end

            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.iord      = 1'b0;
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = SRCB_ONE;
                bus.alu_op    = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = DECODE;
            end

            DECODE: begin
                bus.alu_src_a = 1'b0;
                bus.alu_src_b = SRCB_BRANCH;
                bus.alu_op    = ALU_ADD;
                // Opcode is only looked at here; later states use what was captured.
                case (bus.opcode)
                    OP_RTYPE: state_d = EXEC_R;
                    OP_ADDI: begin
                        state_d     = EXEC_I;
                        exec_i_op_d = ALU_ADD;
                    end
                    OP_ANDI: begin
                        state_d     = EXEC_I;
                        exec_i_op_d = ALU_AND;
                    end
                    OP_ORI: begin
                        state_d     = EXEC_I;
                        exec_i_op_d = ALU_OR;
                    end
                    OP_SLTI: begin
                        state_d     = EXEC_I;
                        exec_i_op_d = ALU_SLT;
                    end
                    OP_LW: begin
                        state_d    = MEM_ADDR;
                        is_store_d = 1'b0;
                    end
                    OP_SW: begin
                        state_d    = MEM_ADDR;
                        is_store_d = 1'b1;
                    end
                    OP_BEQ:  state_d = BRANCH;
                    OP_J:    state_d = JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default: state_d = TRAP;
`else
                    default: state_d = FETCH;
`endif
                endcase
            end

            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_RT;
                bus.alu_op    = ALU_RTYPE;
                state_d       = WB_R;
            end

            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = exec_i_op_q;
                state_d       = WB_I;
            end

            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALU_ADD;
                state_d       = is_store_q ? MEM_WR : MEM_RD;
            end

            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end

            MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

            MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
                if (bus.mem_ready) state_d = FETCH;
            end

            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = SRCB_RT;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
                bus.instr_done    = 1'b1;
                state_d           = FETCH;
            end

            JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCSRC_JUMP;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

            WB_R: begin
                bus.reg_dst    = 1'b1;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

            WB_I: begin
                bus.reg_dst    = 1'b0;
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end

`ifdef MC_ILLEGAL_TRAP_EN
            TRAP: begin
                bus.illegal_op = 1'b1;
                state_d        = TRAP;
            end
`endif

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Directed self-checking bench for mc_main_control; honours MC_ILLEGAL_TRAP_EN if defined.
module tb_mc_main_control;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    mc_ctrl_if bus ();

    mc_main_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view of every DUT output: pw pwc psrc[2] iord mr mw irw rd m2r rw sa sb[2] aop[4] done ill
    logic [19:0] obs;
    assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.iord, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.instr_done, bus.illegal_op};

    localparam logic [19:0] F_PW   = 20'h80000;
    localparam logic [19:0] F_PWC  = 20'h40000;
    localparam logic [19:0] PS01   = 20'h10000;
    localparam logic [19:0] PS10   = 20'h20000;
    localparam logic [19:0] F_IORD = 20'h08000;
    localparam logic [19:0] F_MR   = 20'h04000;
    localparam logic [19:0] F_MW   = 20'h02000;
    localparam logic [19:0] F_IRW  = 20'h01000;
    localparam logic [19:0] F_RD   = 20'h00800;
    localparam logic [19:0] F_M2R  = 20'h00400;
    localparam logic [19:0] F_RW   = 20'h00200;
    localparam logic [19:0] F_SA   = 20'h00100;
    localparam logic [19:0] SB01   = 20'h00040;
    localparam logic [19:0] SB10   = 20'h00080;
    localparam logic [19:0] SB11   = 20'h000C0;
    localparam logic [19:0] A_ADD  = 20'h00004;
    localparam logic [19:0] A_SUB  = 20'h00010;
    localparam logic [19:0] A_SLT  = 20'h00018;
    localparam logic [19:0] A_AND  = 20'h00024;
    localparam logic [19:0] A_OR   = 20'h00028;
    localparam logic [19:0] F_DONE = 20'h00002;
    localparam logic [19:0] F_ILL  = 20'h00001;

    localparam logic [19:0] V_ZERO     = 20'h0;
    localparam logic [19:0] V_FETCH    = F_PW | F_MR | F_IRW | SB01 | A_ADD;
    localparam logic [19:0] V_FETCH_WT = F_MR | SB01 | A_ADD;
    localparam logic [19:0] V_DECODE   = SB11 | A_ADD;
    localparam logic [19:0] V_EXEC_R   = F_SA;
    localparam logic [19:0] V_WB_R     = F_RD | F_RW | F_DONE;
    localparam logic [19:0] V_WB_I     = F_RW | F_DONE;
    localparam logic [19:0] V_MEM_ADDR = F_SA | SB10 | A_ADD;
    localparam logic [19:0] V_MEM_RD   = F_IORD | F_MR;
    localparam logic [19:0] V_MEM_WB   = F_M2R | F_RW | F_DONE;
    localparam logic [19:0] V_MEM_WR   = F_IORD | F_MW;
    localparam logic [19:0] V_BRANCH   = F_SA | F_PWC | PS01 | A_SUB | F_DONE;
    localparam logic [19:0] V_JUMP     = F_PW | PS10 | F_DONE;

    task automatic check(input string tag, input logic [19:0] observed, input logic [19:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset_n         = 1'b0;
        bus.opcode      = 4'b0000;
        bus.mem_ready   = 1'b1;

        #12;
        check("reset_zero", obs, V_ZERO);
        #1 reset_n = 1'b1;
        tick(); check("idle_first_edge", obs, V_ZERO);
        tick(); check("fetch_second_edge", obs, V_FETCH);

        // Reset mid-FETCH, then release.
        #1 reset_n = 1'b0;
        #1 check("reset_mid_fetch", obs, V_ZERO);
        reset_n = 1'b1;
        tick(); check("idle_after_abort", obs, V_ZERO);
        tick(); check("fetch_after_abort", obs, V_FETCH);

        // R-type, zero wait.
        bus.opcode = 4'b0000;
        tick(); check("r_decode", obs, V_DECODE);
        tick(); check("r_exec", obs, V_EXEC_R);
        tick(); check("r_wb", obs, V_WB_R);
        tick(); check("r_next_fetch", obs, V_FETCH);

        // lw with three wait cycles in MEM_RD.
        bus.opcode = 4'b0101;
        tick(); check("lw_decode", obs, V_DECODE);
        tick(); check("lw_mem_addr", obs, V_MEM_ADDR);
        bus.mem_ready = 1'b0;
        tick(); check("lw_mem_rd_1", obs, V_MEM_RD);
        tick(); check("lw_mem_rd_2", obs, V_MEM_RD);
        tick(); check("lw_mem_rd_3", obs, V_MEM_RD);
        tick();
        bus.mem_ready = 1'b1;
        #1 check("lw_mem_rd_4", obs, V_MEM_RD);
        tick(); check("lw_mem_wb", obs, V_MEM_WB);
        tick(); check("lw_next_fetch", obs, V_FETCH);

        // FETCH wait, then beq; opcode and mem_ready wiggled where they must be ignored.
        bus.opcode    = 4'b0111;
        bus.mem_ready = 1'b0;
        #1 check("fetch_wait_1", obs, V_FETCH_WT);
        tick(); check("fetch_wait_2", obs, V_FETCH_WT);
        bus.mem_ready = 1'b1;
        #1 check("fetch_ready", obs, V_FETCH);
        tick(); check("beq_decode", obs, V_DECODE);
        bus.mem_ready = 1'b0;
        tick();
        bus.opcode = 4'b0000;
        #1 check("beq_branch", obs, V_BRANCH);
        bus.mem_ready = 1'b1;
        tick(); check("beq_next_fetch", obs, V_FETCH);

        // I-type ALU ops.
        bus.opcode = 4'b0010;
        tick(); tick(); check("andi_exec", obs, F_SA | SB10 | A_AND);
        tick(); check("andi_wb", obs, V_WB_I);
        tick(); check("andi_next_fetch", obs, V_FETCH);
        bus.opcode = 4'b0011;
        tick(); tick(); check("ori_exec", obs, F_SA | SB10 | A_OR);
        tick(); tick();
        bus.opcode = 4'b0100;
        tick(); tick(); check("slti_exec", obs, F_SA | SB10 | A_SLT);
        tick(); tick();
        bus.opcode = 4'b0001;
        tick(); tick(); check("addi_exec", obs, F_SA | SB10 | A_ADD);
        tick(); check("addi_wb", obs, V_WB_I);
        tick();

        // Jump.
        bus.opcode = 4'b1000;
        tick(); check("j_decode", obs, V_DECODE);
        tick(); check("j_jump", obs, V_JUMP);
        tick(); check("j_next_fetch", obs, V_FETCH);

        // sw, zero wait.
        bus.opcode = 4'b0110;
        tick(); tick(); check("sw_mem_addr", obs, V_MEM_ADDR);
        tick(); check("sw_mem_wr_done", obs, V_MEM_WR | F_DONE);
        tick(); check("sw_next_fetch", obs, V_FETCH);

        // sw aborted by reset while mem_write is asserted.
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick(); check("sw_mem_wr_wait", obs, V_MEM_WR);
        #1 reset_n = 1'b0;
        #1 check("sw_reset_drops_write", obs, V_ZERO);
        bus.mem_ready = 1'b1;
        reset_n       = 1'b1;
        tick(); check("sw_restart_idle", obs, V_ZERO);
        tick(); check("sw_restart_fetch", obs, V_FETCH);

        // Undefined opcode.
        bus.opcode = 4'b1111;
        tick(); check("undef_decode", obs, V_DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 100; i++) begin
            tick();
            check("trap_hold", obs, F_ILL);
        end
        #1 reset_n = 1'b0;
        #1 check("trap_cleared_by_reset", obs, V_ZERO);
        reset_n = 1'b1;
        tick(); tick(); check("trap_restart_fetch", obs, V_FETCH);
`else
        tick(); check("undef_nop_fetch", obs, V_FETCH);
        bus.opcode = 4'b0000;
        tick(); tick(); tick(); check("after_nop_wb_r", obs, V_WB_R);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
